vga_scaler_timing: RTL

VGA_SCALER_TIMING -- requirements
Module: vga_scaler_timing

---
 rtl/vga_scaler_timing_if.sv | 28 ++
 rtl/vga_scaler_timing.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_scaler_timing_if.sv
// Video-side bundle of the VGA scaler timing generator: the mode select in, DAC timing and frame-buffer address out.
// The master drives every output from one registered (h,v) snapshot, so all outputs are aligned on the same CLK25 edge.
interface vga_scaler_timing_if #(
  parameter int ADDR_W = 17
) ();
  logic              scale_sel;
  logic              clkout;
  logic              Hsync;
  logic              Vsync;
  logic              Nblank;
  logic              Nsync;
  logic              activeArea;
  logic [ADDR_W-1:0] pixel_address;
  logic              frame_start;
  logic              line_start;

  modport master (
    input  scale_sel,
    output clkout, Hsync, Vsync, Nblank, Nsync, activeArea,
    output pixel_address, frame_start, line_start
  );

  modport slave (
    output scale_sel,
    input  clkout, Hsync, Vsync, Nblank, Nsync, activeArea,
    input  pixel_address, frame_start, line_start
  );
endinterface

// File: rtl/vga_scaler_timing.sv
// VGA raster timing with a centred source window shown at 1x or 2x nearest-neighbour scale.
// The frame-buffer address is built incrementally from a line-base register and a running pixel address.
module vga_scaler_timing #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SRC_W     = 320,
  parameter int SRC_H     = 240,
  parameter int ADDR_W    = 17
) (
  input  logic                 CLK25,
  input  logic                 RST,
  vga_scaler_timing_if.master  vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  // Window bounds for each scale; the upper bound is exclusive.
  localparam logic [HW-1:0] X0_1 = HW'((H_DISPLAY - SRC_W) / 2);
  localparam logic [HW-1:0] X1_1 = HW'((H_DISPLAY - SRC_W) / 2 + SRC_W);
  localparam logic [HW-1:0] X0_2 = HW'((H_DISPLAY - 2 * SRC_W) / 2);
  localparam logic [HW-1:0] X1_2 = HW'((H_DISPLAY - 2 * SRC_W) / 2 + 2 * SRC_W);
  localparam logic [VW-1:0] Y0_1 = VW'((V_DISPLAY - SRC_H) / 2);
  localparam logic [VW-1:0] Y1_1 = VW'((V_DISPLAY - SRC_H) / 2 + SRC_H);
  localparam logic [VW-1:0] Y0_2 = VW'((V_DISPLAY - 2 * SRC_H) / 2);
  localparam logic [VW-1:0] Y1_2 = VW'((V_DISPLAY - 2 * SRC_H) / 2 + 2 * SRC_H);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic              mode_q, mode_d;
  logic              hphase_q, hphase_d;
  logic              vphase_q, vphase_d;
  logic [ADDR_W-1:0] run_q, run_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              hsync_q, vsync_q, nblank_q, active_q, fs_q, ls_q;
  logic [ADDR_W-1:0] addr_q;

  logic          h_wrap, v_wrap, frame_wrap;
  logic [HW-1:0] x0, x1;
  logic [VW-1:0] y0, y1;
  logic          x_in, y_in, in_win;

  always_comb begin
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    x0         = mode_q ? X0_2 : X0_1;
    x1         = mode_q ? X1_2 : X1_1;
    y0         = mode_q ? Y0_2 : Y0_1;
    y1         = mode_q ? Y1_2 : Y1_1;
    x_in       = (h_q >= x0) && (h_q < x1);
    y_in       = (v_q >= y0) && (v_q < y1);
    in_win     = x_in && y_in;

    h_d      = h_wrap ? '0 : h_q + HW'(1);
    v_d      = h_wrap ? (v_wrap ? '0 : v_q + VW'(1)) : v_q;
    mode_d   = mode_q;
    hphase_d = hphase_q;
    vphase_d = vphase_q;
    run_d    = run_q;
    base_d   = base_q;

    if (frame_wrap) begin
      // The mode is only ever taken on the wrap to (0,0), so window bounds are stable for a whole frame.
      mode_d   = vga.scale_sel;
      hphase_d = 1'b0;
      vphase_d = 1'b0;
      run_d    = '0;
      base_d   = '0;
    end else if (h_wrap) begin
      // At 2x a source line is shown twice, so the base moves only after the odd window line.
      if (y_in) begin
        vphase_d = ~vphase_q;
        if (!mode_q || vphase_q) base_d = base_q + LINE_STEP;
      end
      hphase_d = 1'b0;
      run_d    = base_d;
    end else if (in_win) begin
      hphase_d = ~hphase_q;
      if (!mode_q || hphase_q) run_d = run_q + ONE;
    end
  end

  always_ff @(posedge CLK25) begin
    if (RST) begin
      h_q      <= '0;
      v_q      <= '0;
      mode_q   <= vga.scale_sel;
      hphase_q <= 1'b0;
      vphase_q <= 1'b0;
      run_q    <= '0;
      base_q   <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      nblank_q <= 1'b0;
      active_q <= 1'b0;
      addr_q   <= '0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      mode_q   <= mode_d;
      hphase_q <= hphase_d;
      vphase_q <= vphase_d;
      run_q    <= run_d;
      base_q   <= base_d;
      hsync_q  <= !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_q  <= !((v_q >= VS_BEG) && (v_q < VS_END));
      nblank_q <= (h_q < H_DISP) && (v_q < V_DISP);
      active_q <= in_win;
      addr_q   <= in_win ? run_q : '0;
      fs_q     <= (h_q == '0) && (v_q == '0);
      ls_q     <= (h_q == '0);
    end
  end

  assign vga.clkout        = CLK25;
  assign vga.Nsync         = 1'b1;
  assign vga.Hsync         = hsync_q;
  assign vga.Vsync         = vsync_q;
  assign vga.Nblank        = nblank_q;
  assign vga.activeArea    = active_q;
  assign vga.pixel_address = addr_q;
  assign vga.frame_start   = fs_q;
  assign vga.line_start    = ls_q;
endmodule
